// File: rtl/de0_comm_pkg.sv
// Shared types and constants for the DE0 serial-link self-test.
// The state enum is common to the transmit and receive machines.
`timescale 1ns/1ps
package de0_comm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } fsm_state_t;

   localparam int DATA_BITS      = 8;
   localparam int BIT_IDX_W      = $clog2(DATA_BITS);
   localparam int DEF_CLK_DIV    = 434;
   localparam int DEF_GAP_CYCLES = 1000;

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_serdes.sv
// 8N1 UART transmitter and receiver with a 2-flop input synchronizer.
// Both directions share the same bit period of CLK_DIV clocks.
`timescale 1ns/1ps
module uart_serdes
   import de0_comm_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       send,
   output logic       busy,
   output logic       tx,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid
);

   localparam int CW = cnt_width(CLK_DIV);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
   localparam logic [BIT_IDX_W-1:0] IDX_ONE  = BIT_IDX_W'(1);
   localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

   fsm_state_t tx_state, tx_next;
   logic [CW-1:0] tx_cnt;
   logic [BIT_IDX_W-1:0] tx_idx;
   logic [7:0] tx_shift;
   logic tx_bit_end;

   assign tx_bit_end = (tx_cnt == BIT_END);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
      end else begin
         tx_state <= tx_next;
         if (tx_state == IDLE) begin
            tx_cnt <= '0;
            tx_idx <= '0;
            if (send)
               tx_shift <= tx_data;
         end else if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_state == DATA) begin
               tx_shift <= {1'b0, tx_shift[7:1]};
               tx_idx   <= tx_idx + IDX_ONE;
            end
         end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
         end
      end
   end

   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         IDLE:    if (send) tx_next = START;
         START:   if (tx_bit_end) tx_next = DATA;
         DATA:    if (tx_bit_end && tx_idx == IDX_LAST) tx_next = STOP;
         STOP:    if (tx_bit_end) tx_next = IDLE;
         default: tx_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (tx_state != IDLE);
      tx   = 1'b1;
      case (tx_state)
         START:   tx = 1'b0;
         DATA:    tx = tx_shift[0];
         default: tx = 1'b1;
      endcase
   end

   // Receiver: IDLE only ever sees a high line on entry, so a low level there is the falling edge.
   logic rx_s1, rx_s2;
   fsm_state_t rx_state, rx_next;
   logic [CW-1:0] rx_cnt;
   logic [BIT_IDX_W-1:0] rx_idx;
   logic [7:0] rx_shift;
   logic rx_err;
   logic rx_half_end, rx_bit_end;

   assign rx_half_end = (rx_cnt == HALF_END);
   assign rx_bit_end  = (rx_cnt == BIT_END);
   assign rx_data     = rx_shift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_shift <= '0;
         rx_err   <= 1'b0;
      end else begin
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_state <= rx_next;
         case (rx_state)
            IDLE: begin
               rx_cnt <= '0;
               rx_idx <= '0;
               rx_err <= 1'b0;
            end
            START: rx_cnt <= rx_half_end ? '0 : rx_cnt + CNT_ONE;
            DATA: begin
               if (rx_bit_end) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_idx   <= rx_idx + IDX_ONE;
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            STOP: begin
               if (!rx_err) begin
                  if (rx_bit_end)
                     rx_err <= ~rx_s2;
                  else
                     rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            default: rx_cnt <= '0;
         endcase
      end
   end

   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         IDLE:  if (!rx_s2) rx_next = START;
         START: if (rx_half_end) rx_next = rx_s2 ? IDLE : DATA;
         DATA:  if (rx_bit_end && rx_idx == IDX_LAST) rx_next = STOP;
         STOP: begin
            if (rx_err) begin
               if (rx_s2) rx_next = IDLE;
            end else if (rx_bit_end && rx_s2) begin
               rx_next = IDLE;
            end
         end
         default: rx_next = IDLE;
      endcase
   end

   always_comb begin
      rx_valid = (rx_state == STOP) && !rx_err && rx_bit_end && rx_s2;
   end

endmodule

// File: rtl/de0_comm.sv
// DE0 serial-link self-test: an incrementing byte is sent over a looped-back
// UART and every correctly framed byte received is latched onto the LEDs.
`timescale 1ns/1ps
module de0_comm
   import de0_comm_pkg::*;
#(
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
)
(
   input  logic       CLOCK_50,
   input  logic       areset,
   output logic [7:0] LED
);

   localparam int GW = cnt_width(GAP_CYCLES);
   localparam logic [GW-1:0] GAP_ONE = GW'(1);
   localparam logic [GW-1:0] GAP_END = GW'(GAP_CYCLES - 1);

   logic [7:0] pattern, next_pattern, rx_data;
   logic [GW-1:0] gap_cnt;
   logic send, busy, rx_valid;
   logic tx_line, loop_line;

   assign next_pattern = pattern + 8'd1;
   assign send         = !busy && (gap_cnt == GAP_END);
   assign loop_line    = tx_line;

   // The gap count is held at zero while a frame is on the line, so it restarts when STOP ends.
   always_ff @(posedge CLOCK_50 or posedge areset) begin
      if (areset) begin
         pattern <= 8'h00;
         gap_cnt <= '0;
         LED     <= 8'h00;
      end else begin
         if (busy) begin
            gap_cnt <= '0;
         end else if (send) begin
            gap_cnt <= '0;
            pattern <= next_pattern;
         end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
         end
         if (rx_valid)
            LED <= rx_data;
      end
   end

   uart_serdes #(
      .CLK_DIV (CLK_DIV)
   ) u_serdes (
      .clk      (CLOCK_50),
      .rst      (areset),
      .tx_data  (next_pattern),
      .send     (send),
      .busy     (busy),
      .tx       (tx_line),
      .rx       (loop_line),
      .rx_data  (rx_data),
      .rx_valid (rx_valid)
   );

endmodule

// File: tb/tb_de0_comm.sv
// Scoreboard bench for de0_comm: stimulus predicts each frame's LED value and
// arrival cycle, a monitor pops and compares whenever the LEDs change.
`timescale 1ns/1ps
module tb_de0_comm;

   localparam int CLK_DIV    = 8;
   localparam int GAP_CYCLES = 16;
   localparam int PERIOD     = 10 * CLK_DIV + GAP_CYCLES;
   localparam int LATENCY    = 2 + 9 * CLK_DIV + CLK_DIV / 2 + 1;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   logic       CLOCK_50 = 1'b0;
   logic       areset   = 1'b0;
   logic [7:0] LED;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;

   de0_comm #(
      .CLK_DIV    (CLK_DIV),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .areset   (areset),
      .LED      (LED)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic check_output(input string name, input int actual, input int required);
      n_checks++;
      if (actual != required) begin
         n_fail++;
         $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   task automatic goto_cycle(input int target);
      do @(negedge CLOCK_50); while (cyc < target);
   endtask

   // Checks the start bit of a frame beginning at cycle s and queues its expected LED result.
   task automatic apply_stimulus(input logic [7:0] b, input int s, input bit expect_rx, input bit wave);
      logic [9:0] bits;
      exp_t e;
      bits = {1'b1, b, 1'b0};
      goto_cycle(s - 1);
      check_output("tx idle before start", int'(dut.loop_line), 1);
      goto_cycle(s);
      check_output("tx start bit", int'(dut.loop_line), 0);
      if (expect_rx) begin
         e.data = b;
         e.due  = s + LATENCY;
         sb.push_back(e);
      end
      if (wave) begin
         for (int k = 0; k < 10; k++) begin
            goto_cycle(s + k * CLK_DIV + CLK_DIV / 2);
            check_output($sformatf("tx bit %0d", k), int'(dut.loop_line), int'(bits[k]));
         end
      end
   endtask

   initial begin : monitor
      logic [7:0] last_led;
      exp_t e;
      wait (mon_en);
      last_led = LED;
      forever begin
         @(negedge CLOCK_50);
         if (areset) begin
            last_led = LED;
         end else if (LED != last_led) begin
            if (sb.size() == 0) begin
               check_output("unexpected LED update", int'(LED), int'(last_led));
            end else begin
               e = sb.pop_front();
               check_output("LED value", int'(LED), int'(e.data));
               check_output("LED latency", cyc, e.due);
            end
            last_led = LED;
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      int s;
      int rel;
      #1 areset = 1'b1;
      #1;
      check_output("reset LED", int'(LED), 8'h00);
      check_output("reset tx idle", int'(dut.loop_line), 1);
      #1 areset = 1'b0;
      mon_en = 1'b1;

      s = GAP_CYCLES;
      apply_stimulus(8'h01, s, 1'b1, 1'b1);
      for (int i = 2; i <= 256; i++) begin
         s += PERIOD;
         apply_stimulus(8'(i), s, 1'b1, 1'b0);
      end

      // Frame carrying 0x01 with its stop bit forced low: LED must hold 0x00.
      s += PERIOD;
      apply_stimulus(8'h01, s, 1'b0, 1'b0);
      goto_cycle(s + 9 * CLK_DIV);
      force dut.loop_line = 1'b0;
      goto_cycle(s + 10 * CLK_DIV);
      release dut.loop_line;
      goto_cycle(s + 10 * CLK_DIV + 5);
      check_output("framing error holds LED", int'(LED), 8'h00);

      s += PERIOD;
      apply_stimulus(8'h02, s, 1'b1, 1'b0);

      // Two-cycle low glitch in the idle gap.
      goto_cycle(s + 10 * CLK_DIV + 2);
      force dut.loop_line = 1'b0;
      goto_cycle(s + 10 * CLK_DIV + 4);
      release dut.loop_line;
      goto_cycle(s + 10 * CLK_DIV + 12);
      check_output("glitch ignored", int'(LED), 8'h02);

      s += PERIOD;
      apply_stimulus(8'h03, s, 1'b1, 1'b0);

      // Reset in the middle of the DATA phase of the next frame.
      s += PERIOD;
      apply_stimulus(8'h04, s, 1'b0, 1'b0);
      goto_cycle(s + 30);
      #2 areset = 1'b1;
      #3;
      check_output("mid-frame reset LED", int'(LED), 8'h00);
      check_output("mid-frame reset tx idle", int'(dut.loop_line), 1);
      #20 areset = 1'b0;
      rel = cyc;

      apply_stimulus(8'h01, rel + GAP_CYCLES, 1'b1, 1'b1);
      goto_cycle(rel + GAP_CYCLES + LATENCY + 3);
      check_output("LED after reset recovery", int'(LED), 8'h01);
      check_output("scoreboard drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
